// File: rtl/alu_pkg.sv
// Shared ALU sequencer definitions: FSM state encoding and default slice width.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int ALU_SLICE_W = 3;

endpackage

// File: rtl/add_ripple.sv
// Combinational W-bit ripple-carry slice adder.
module add_ripple #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out
);

    logic [W:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[W];

endmodule

// File: rtl/add_chain_seq.sv
// Multi-cycle wide adder: walks one add_ripple slice per cycle, LSB first,
// carrying between slices through carry_reg.
module add_chain_seq
    import alu_pkg::*;
#(
    parameter int SLICE_W    = ALU_SLICE_W,
    parameter int NUM_SLICES = 4,
    localparam int W         = SLICE_W * NUM_SLICES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    alu_state_e         state;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       work_reg;
    logic               carry_reg;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_c;
    logic [W-1:0]       work_next;
    logic               ovf_next;

    // Constant-offset slice mux keeps the part-selects static.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx == IDX_W'(i)) begin
                sl_a = a_reg[i*SLICE_W +: SLICE_W];
                sl_b = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
    end

    add_ripple #(.W(SLICE_W)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry_reg),
        .s     (sl_s),
        .c_out (sl_c)
    );

    always_comb begin
        work_next = work_reg;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx == IDX_W'(i)) begin
                work_next[i*SLICE_W +: SLICE_W] = sl_s;
            end
        end
        ovf_next = (a_reg[W-1] == b_reg[W-1]) && (work_next[W-1] != a_reg[W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= c_in;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work_reg  <= work_next;
                    carry_reg <= sl_c;
                    if (idx == LAST_IDX) begin
                        sum   <= work_next;
                        c_out <= sl_c;
                        ovf   <= ovf_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_chain_seq.sv
// Directed bench for add_chain_seq: default 4x3-bit instance plus an
// exhaustive sweep of a 2x3-bit instance.
module tb_add_chain_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] a;
    logic [11:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [11:0] sum;
    logic        c_out;
    logic        ovf;

    logic        start2;
    logic [5:0]  a2;
    logic [5:0]  b2;
    logic        c2;
    logic        busy2;
    logic        done2;
    logic [5:0]  sum2;
    logic        cout2;
    logic        ovf2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    add_chain_seq #(.SLICE_W(3), .NUM_SLICES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    add_chain_seq #(.SLICE_W(3), .NUM_SLICES(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .c_in  (c2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .c_out (cout2),
        .ovf   (ovf2)
    );

    // Drive one start; returns just after the accepting edge (edge 0).
    task automatic issue(input logic [11:0] ia, input logic [11:0] ib, input logic ic);
        @(posedge clk);
        #1 a = ia; b = ib; c_in = ic; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                cyc  = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 12'h001; b = 12'h001; c_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (sum !== 12'h000) begin fails++; $display("FAIL reset_sum got=%h exp=000", sum); end
        tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL reset_cout got=%b exp=0", c_out); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        tests++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin fails++; $display("FAIL reset_dut2 busy=%b done=%b exp=0,0", busy2, done2); end
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_no_start got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        logic exp_busy, exp_done;
        issue(12'h001, 12'h001, 1'b0);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            exp_busy = (cyc <= 4);
            exp_done = (cyc == 5);
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            tests++; if (done !== exp_done) begin fails++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
            if (cyc == 5) begin
                tests++;
                if ({c_out, sum, ovf} !== {1'b0, 12'h002, 1'b0}) begin
                    fails++; $display("FAIL basic_result got c=%b s=%h v=%b exp c=0 s=002 v=0", c_out, sum, ovf);
                end
            end
        end
    endtask

    task automatic test_ripple();
        logic [11:0] va [3] = '{12'hFFF, 12'h7FF, 12'h800};
        logic [11:0] vb [3] = '{12'h001, 12'h001, 12'h800};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [11:0] es [3] = '{12'h000, 12'h800, 12'h001};
        logic        ec [3] = '{1'b1, 1'b0, 1'b1};
        logic        eo [3] = '{1'b0, 1'b1, 1'b1};
        int cyc;
        bit seen;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], vc[i]);
            wait_done(cyc, seen);
            tests++;
            if (!seen || cyc != 5) begin
                fails++; $display("FAIL ripple%0d_latency seen=%b cyc=%0d exp cyc=5", i, seen, cyc);
            end
            tests++;
            if ({c_out, sum, ovf} !== {ec[i], es[i], eo[i]}) begin
                fails++; $display("FAIL ripple%0d_result got c=%b s=%h v=%b exp c=%b s=%h v=%b",
                                  i, c_out, sum, ovf, ec[i], es[i], eo[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        int ndone = 0;
        int first = 0;
        issue(12'h123, 12'h456, 1'b0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin a = 12'hFFF; b = 12'hFFF; start = 1'b1; end
            if (cyc == 3) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = cyc;
            end
        end
        tests++; if (ndone != 1 || first != 5) begin fails++; $display("FAIL busy_start_done count=%0d first=%0d exp 1 at 5", ndone, first); end
        tests++; if ({c_out, sum} !== {1'b0, 12'h579}) begin fails++; $display("FAIL busy_start_sum got c=%b s=%h exp c=0 s=579", c_out, sum); end
    endtask

    task automatic test_mid_reset();
        int ndone = 0;
        int cyc;
        bit seen;
        issue(12'h555, 12'h111, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) begin
                tests++;
                if ({busy, sum, c_out, ovf} !== {1'b0, 12'h000, 1'b0, 1'b0}) begin
                    fails++; $display("FAIL midrst_state busy=%b s=%h c=%b v=%b exp 0,000,0,0", busy, sum, c_out, ovf);
                end
            end
            if (done === 1'b1) ndone++;
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
        end
        tests++; if (ndone != 0) begin fails++; $display("FAIL midrst_no_done count=%0d exp 0", ndone); end
        issue(12'hABC, 12'h544, 1'b1);
        wait_done(cyc, seen);
        tests++;
        if (!seen || cyc != 5 || {c_out, sum, ovf} !== {1'b1, 12'h001, 1'b0}) begin
            fails++; $display("FAIL midrst_fresh seen=%b cyc=%0d c=%b s=%h v=%b exp cyc=5 c=1 s=001 v=0",
                              seen, cyc, c_out, sum, ovf);
        end
    endtask

    task automatic test_exhaustive();
        logic [12:0] n;
        logic [6:0]  tot;
        logic [9:0]  got, exp;
        logic        d1, d2, d3, eovf;
        int          sa, sb, st;
        for (int i = 0; i < 8192; i++) begin
            n  = 13'(i);
            a2 = n[12:7]; b2 = n[6:1]; c2 = n[0]; start2 = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk); d1 = done2;
            @(negedge clk); d2 = done2;
            @(negedge clk); d3 = done2;
            tot  = {1'b0, a2} + {1'b0, b2} + {6'b0, c2};
            sa   = a2[5] ? int'(a2) - 64 : int'(a2);
            sb   = b2[5] ? int'(b2) - 64 : int'(b2);
            st   = sa + sb + int'(c2);
            eovf = (st > 31) || (st < -32);
            got  = {d1, d2, d3, cout2, sum2, ovf2};
            exp  = {1'b0, 1'b0, 1'b1, tot[6], tot[5:0], eovf};
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL exh a=%h b=%h ci=%b got dones=%b%b%b c=%b s=%h v=%b exp dones=001 c=%b s=%h v=%b",
                                  a2, b2, c2, d1, d2, d3, cout2, sum2, ovf2, tot[6], tot[5:0], eovf);
            end
            @(posedge clk);
            #1;
        end
        start2 = 1'b0;
    endtask

    initial begin
        start2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_start_busy();
        test_mid_reset();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
